mcu_cycle_gen: RTL and testbench
================================

MCU_CYCLE_GEN -- requirements
Module: mcu_cycle_gen

Interface
REQ-001 SHALL have parameter CYC_W, default 2: width of inst_cycles; an instruction lasts inst_cycles+1 machine cycles (1..2^CYC_W).
REQ-002 SHALL have port clk_in  input  1  single system clock; all logic on posedge clk_in.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port clk_div  input  1  divided clock level from the upstream clock divider, sampled as data in the clk_in domain.
REQ-005 SHALL have port hold  input  1  wait-state request; freezes sequencing while high.
REQ-006 SHALL have port inst_start  input  1  request to begin an instruction.
REQ-007 SHALL have port inst_cycles  input  CYC_W  machine-cycle count minus 1, sampled with accepted inst_start.
REQ-008 SHALL have port busy  output  1  instruction in progress.
REQ-009 SHALL have port s_state  output  3  current 8051 state S1..S6, encoded 1..6.
REQ-010 SHALL have port phase  output  1  0 = P1, 1 = P2.
REQ-011 SHALL have port mc_end  output  1  one-cycle pulse at the end of each machine cycle.
REQ-012 SHALL have port inst_done  output  1  one-cycle pulse at the end of the last machine cycle.
REQ-013 SHALL have port ale  output  1  address latch enable.

Function
REQ-014 SHALL register clk_div into clk_div_q; tick = clk_div & ~clk_div_q & ~hold, where a tick is one rising edge of clk_div.
REQ-015 SHALL keep a 4-bit position counter pos 0..11, where S1P1=0 and S6P2=11; s_state = pos/2+1 and phase = pos[0].
REQ-016 SHALL implement FSM IDLE/RUN; in IDLE, pos SHALL hold at 0, busy=0, and ticks are ignored.
REQ-017 SHALL accept inst_start in IDLE on the same clk_in edge: load rem=inst_cycles, go to RUN, busy=1 from the next cycle, pos=0.
REQ-018 In RUN, each tick SHALL advance pos by 1, with the update visible in the cycle after the tick; pos 11 wraps to 0.
REQ-019 On a tick at pos=11, mc_end SHALL pulse high for exactly the following clk_in cycle.
REQ-020 On a tick at pos=11 with rem>0, the block SHALL decrement rem and stay in RUN.
REQ-021 On a tick at pos=11 with rem=0, inst_done SHALL pulse for one cycle, then: if inst_start=1 in that same cycle, reload rem and stay in RUN with no gap; else go to IDLE.
REQ-022 In RUN, inst_start SHALL be ignored except in the cycle of the final tick (REQ-021).
REQ-023 With hold=1, a coincident clk_div rising edge SHALL be discarded, not deferred; pos and rem are frozen.
REQ-024 ale SHALL be a decode of registered state: 1 in RUN when pos is in {1,2,7,8} (S1P2, S2P1, S4P2, S5P1), else 0, adding no extra latency beyond pos.
REQ-025 rem SHALL be CYC_W bits wide, and its decrement SHALL never underflow.

Reset
REQ-026 On rst=1 at a clk_in edge, including mid-instruction, the next-cycle outputs SHALL be: busy=0, s_state=1, phase=0, mc_end=0, inst_done=0, ale=0; FSM=IDLE, pos=0, rem=0.
REQ-027 clk_div_q SHALL reset to 1, so a clk_div held high through reset release produces no tick.
REQ-028 While rst=1, inst_start SHALL be ignored; rst has priority over every other input.

Configuration
REQ-029 Macro MCU_CYCLE_GEN_ALE_EN defined: ale is generated per REQ-024.
REQ-030 Macro MCU_CYCLE_GEN_ALE_EN undefined: ale is tied to constant 0 and no ALE decode logic exists; all other behaviour is identical.

Verification
REQ-031 Reset release with clk_div=1, then no further clk_div edges -> no tick; s_state=1, phase=0, busy=0.
REQ-032 clk_div period 3 clocks, inst_start with inst_cycles=0 -> busy=1 for exactly 12 ticks (36 clocks), one mc_end pulse, inst_done coincident with that mc_end, then IDLE.
REQ-033 inst_cycles=1 -> two mc_end pulses 12 ticks apart; inst_done only on the second; s_state sequence 1,1,2,2,...,6,6 repeated twice.
REQ-034 inst_start held high through the final tick -> busy stays 1 and pos returns to 0 with no IDLE cycle; inst_start mid-instruction -> no effect.
REQ-035 hold=1 across 2 clk_div rising edges at pos=5 -> pos stays 5, and the instruction completes 2 edges later than without hold.
REQ-036 With macro defined: ale high in exactly 4 of the 12 positions (1,2,7,8); macro undefined: ale=0 always; rst asserted at pos=7 -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/mcu_cycle_gen_if.sv
// Bus bundle for the 8051-style machine-cycle generator.
// The master drives clock-divider level, wait-state and instruction requests.
// The slave (the generator) returns the S-state/phase timing and its strobes.
interface mcu_cycle_gen_if #(
  parameter int CYC_W = 2
);

  logic             clk_div;
  logic             hold;
  logic             inst_start;
  logic [CYC_W-1:0] inst_cycles;
  logic             busy;
  logic [2:0]       s_state;
  logic             phase;
  logic             mc_end;
  logic             inst_done;
  logic             ale;

  modport master (
    output clk_div, hold, inst_start, inst_cycles,
    input  busy, s_state, phase, mc_end, inst_done, ale
  );

  modport slave (
    input  clk_div, hold, inst_start, inst_cycles,
    output busy, s_state, phase, mc_end, inst_done, ale
  );

endinterface

// File: rtl/mcu_cycle_gen.sv
// 8051-style machine-cycle generator.
// Each rising edge of the divided clock (sampled in the clk_in domain) advances
// a 12-step position S1P1..S6P2; one pass is one machine cycle.
// An instruction spans inst_cycles+1 machine cycles.
// hold discards divider edges, freezing all sequencing.
// Optional feature: define MCU_CYCLE_GEN_ALE_EN to generate ALE.
// Without it, ale is tied low and no decode logic exists.
module mcu_cycle_gen #(
  parameter int CYC_W = 2
) (
  input  logic           clk_in,
  input  logic           rst,
  mcu_cycle_gen_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       pos_q, pos_d;
  logic [CYC_W-1:0] rem_q, rem_d;
  logic             clk_div_q, clk_div_d;
  logic             mc_end_q, mc_end_d;
  logic             inst_done_q, inst_done_d;
  logic             tick;
  logic             last_pos;

  // A tick is a fresh rising edge of clk_div that hold does not suppress.
  // A suppressed edge is simply lost, because clk_div_q still follows clk_div.
  assign tick     = bus.clk_div & ~clk_div_q & ~bus.hold;
  assign last_pos = (pos_q == 4'd11);

  // State register.
  // clk_div_q resets high, so a divider level that is already high at
  // reset release does not count as an edge.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= IDLE;
      pos_q       <= 4'd0;
      rem_q       <= '0;
      clk_div_q   <= 1'b1;
      mc_end_q    <= 1'b0;
      inst_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      rem_q       <= rem_d;
      clk_div_q   <= clk_div_d;
      mc_end_q    <= mc_end_d;
      inst_done_q <= inst_done_d;
    end
  end

  // Next-state logic: instruction accept, position stepping and end-of-cycle bookkeeping.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    rem_d       = rem_q;
    clk_div_d   = bus.clk_div;
    mc_end_d    = 1'b0;
    inst_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        pos_d = 4'd0;
        if (bus.inst_start) begin
          state_d = RUN;
          rem_d   = bus.inst_cycles;
        end
      end
      RUN: begin
        if (tick) begin
          if (last_pos) begin
            pos_d    = 4'd0;
            mc_end_d = 1'b1;
            if (rem_q != '0) begin
              rem_d = rem_q - CYC_W'(1);
            end else begin
              inst_done_d = 1'b1;
              // A new request on the final tick chains straight into the
              // next instruction without passing through IDLE.
              if (bus.inst_start) begin
                rem_d = bus.inst_cycles;
              end else begin
                state_d = IDLE;
              end
            end
          end else begin
            pos_d = pos_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.s_state   = pos_q[3:1] + 3'd1;
  assign bus.phase     = pos_q[0];
  assign bus.mc_end    = mc_end_q;
  assign bus.inst_done = inst_done_q;

`ifdef MCU_CYCLE_GEN_ALE_EN
  // ALE is high during S1P2, S2P1, S4P2 and S5P1.
  // It is decoded straight from registered state, so it has the same latency as pos.
  assign bus.ale = (state_q == RUN) &&
                   ((pos_q == 4'd1) || (pos_q == 4'd2) ||
                    (pos_q == 4'd7) || (pos_q == 4'd8));
`else
  assign bus.ale = 1'b0;
`endif

endmodule

// File: tb/tb_mcu_cycle_gen.sv
// Self-checking bench for mcu_cycle_gen: a directed vector table plus
// hand-written multi-cycle sequences (full instructions, hold, chaining, reset).
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_mcu_cycle_gen;

`ifdef MCU_CYCLE_GEN_ALE_EN
  localparam bit ALE_ON = 1'b1;
`else
  localparam bit ALE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;
  int busy_cnt, mc_cnt, done_cnt, orphan_cnt;

  mcu_cycle_gen_if #(.CYC_W(2)) bus ();

  mcu_cycle_gen #(.CYC_W(2)) dut (
    .clk_in (clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       div;
    logic       hold;
    logic       start;
    logic [1:0] cyc;
    logic       busy;
    logic [2:0] s;
    logic       ph;
    logic       mc;
    logic       done;
    logic       ale_pos;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs for one clk cycle, then sample outputs at the next falling edge.
  task automatic applyStimulus(input logic r, input logic div, input logic hld,
                               input logic st, input logic [1:0] cyc);
    rst             = r;
    bus.clk_div     = div;
    bus.hold        = hld;
    bus.inst_start  = st;
    bus.inst_cycles = cyc;
    @(negedge clk);
    if (bus.busy) busy_cnt++;
    if (bus.mc_end) mc_cnt++;
    if (bus.inst_done) begin
      done_cnt++;
      if (!bus.mc_end) orphan_cnt++;
    end
  endtask

  // One divider period of 3 clocks, with the rising edge in the last cycle.
  task automatic do_tick(input logic hld, input logic st, input logic [1:0] cyc);
    applyStimulus(1'b0, 1'b0, hld, st, cyc);
    applyStimulus(1'b0, 1'b0, hld, st, cyc);
    applyStimulus(1'b0, 1'b1, hld, st, cyc);
  endtask

  task automatic checkOutput(input string name, input logic e_busy, input logic [2:0] e_s,
                             input logic e_ph, input logic e_mc, input logic e_done,
                             input logic e_ale);
    check_val({name, ".busy"}, int'(bus.busy), int'(e_busy));
    check_val({name, ".s_state"}, int'(bus.s_state), int'(e_s));
    check_val({name, ".phase"}, int'(bus.phase), int'(e_ph));
    check_val({name, ".mc_end"}, int'(bus.mc_end), int'(e_mc));
    check_val({name, ".inst_done"}, int'(bus.inst_done), int'(e_done));
    check_val({name, ".ale"}, int'(bus.ale), int'(e_ale));
  endtask

  function automatic logic exp_ale(input int p, input logic b);
    return ALE_ON && b && (p == 1 || p == 2 || p == 7 || p == 8);
  endfunction

  // Check the outputs against an expected position 0..11.
  task automatic check_pos(input string name, input int p, input logic b,
                           input logic mc, input logic done);
    checkOutput(name, b, 3'(p / 2 + 1), p[0], mc, done, exp_ale(p, b));
  endtask

  task automatic clear_stats();
    busy_cnt   = 0;
    mc_cnt     = 0;
    done_cnt   = 0;
    orphan_cnt = 0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Each row is: rst, div, hold, start, cyc, then expected busy, s, ph, mc, done, ale_pos.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};

    clear_stats();
    rst             = 1'b1;
    bus.clk_div     = 1'b1;
    bus.hold        = 1'b0;
    bus.inst_start  = 1'b0;
    bus.inst_cycles = 2'd0;
    @(negedge clk);

    // Vector table: reset, release with clk_div high, idle ticks, accept,
    // discarded hold edge, and an ignored mid-instruction start.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].div, vecs[i].hold, vecs[i].start, vecs[i].cyc);
      checkOutput($sformatf("vec%0d", i), vecs[i].busy, vecs[i].s, vecs[i].ph,
                  vecs[i].mc, vecs[i].done, vecs[i].ale_pos & ALE_ON);
    end

    // Finish the table's instruction from pos 3.
    for (int p = 4; p < 12; p++) begin
      do_tick(1'b0, 1'b0, 2'd0);
      check_pos($sformatf("fin_pos%0d", p), p, 1'b1, 1'b0, 1'b0);
    end
    do_tick(1'b0, 1'b0, 2'd0);
    check_pos("fin_last", 0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    check_pos("fin_idle", 0, 1'b0, 1'b0, 1'b0);

    // A single machine cycle: busy for 36 clocks, one mc_end pulse, done coincident.
    clear_stats();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    for (int k = 0; k < 12; k++) do_tick(1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    check_val("one_mc.busy_cycles", busy_cnt, 36);
    check_val("one_mc.mc_end_pulses", mc_cnt, 1);
    check_val("one_mc.inst_done_pulses", done_cnt, 1);
    check_val("one_mc.done_without_mc", orphan_cnt, 0);
    check_val("one_mc.idle", int'(bus.busy), 0);

    // Two machine cycles: full position walk twice; mc_end on ticks 12 and 24 only.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    check_pos("two_mc.t0", 0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      do_tick(1'b0, 1'b0, 2'd0);
      check_pos($sformatf("two_mc.t%0d", k), k % 12, (k < 24), (k % 12 == 0), (k == 24));
    end

    // Back-to-back: a mid-instruction start is ignored, and a start on the final tick chains.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    for (int k = 1; k <= 11; k++) do_tick(1'b0, (k == 5), 2'd2);
    check_pos("chain.pos11", 11, 1'b1, 1'b0, 1'b0);
    do_tick(1'b0, 1'b1, 2'd0);
    check_pos("chain.final", 0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    check_pos("chain.next", 0, 1'b1, 1'b0, 1'b0);
    clear_stats();
    for (int k = 0; k < 12; k++) do_tick(1'b0, 1'b0, 2'd0);
    check_pos("chain.end", 0, 1'b0, 1'b1, 1'b1);
    check_val("chain.done_pulses", done_cnt, 1);

    // Hold across two divider edges at pos 5: completion is delayed by two edges.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    for (int k = 0; k < 5; k++) do_tick(1'b0, 1'b0, 2'd0);
    check_pos("hold.pos5", 5, 1'b1, 1'b0, 1'b0);
    do_tick(1'b1, 1'b0, 2'd0);
    check_pos("hold.edge1", 5, 1'b1, 1'b0, 1'b0);
    do_tick(1'b1, 1'b0, 2'd0);
    check_pos("hold.edge2", 5, 1'b1, 1'b0, 1'b0);
    clear_stats();
    for (int k = 0; k < 6; k++) do_tick(1'b0, 1'b0, 2'd0);
    check_pos("hold.pos11", 11, 1'b1, 1'b0, 1'b0);
    check_val("hold.early_done", done_cnt, 0);
    do_tick(1'b0, 1'b0, 2'd0);
    check_pos("hold.end", 0, 1'b0, 1'b1, 1'b1);

    // Reset mid-instruction at pos 7; it wins over a coincident tick and start.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
    for (int k = 0; k < 7; k++) do_tick(1'b0, 1'b0, 2'd0);
    check_pos("rst.pos7", 7, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'd3);
    checkOutput("rst.applied", 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    checkOutput("rst.release", 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    checkOutput("rst.restart", 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    checkOutput("rst.no_tick", 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
